pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter of the MIPS front end and sequences the word-address incrementer (PC+1) that computes the sequential next PC.
- Drives the instruction-memory fetch handshake.
- Applies next-PC priority in this order: exception, then branch/jump redirect, then stall, then sequential increment.
- Delivers fetched-instruction valid pulses to decode, and supplies the link value and EPC.

Parameters:
- RESET_PC, 32'h0000_0000, word address loaded on reset.
- EXC_VECTOR, 32'h0000_0020, word address loaded on exception.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  pipeline stall from hazard unit; blocks PC advance.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  target word address, sampled when redirect_valid=1.
- exc_req  in  1  exception request (single-cycle pulse).
- if_req  out  1  fetch request to instruction memory.
- if_addr  out  32  fetch word address; always equals pc.
- if_ack  in  1  memory accepted the request and returned the instruction.
- fetch_valid  out  1  registered one-cycle pulse: instruction at fetch_pc is valid for decode.
- fetch_pc  out  32  PC of the instruction qualified by fetch_valid.
- pc_plus1  out  32  combinational pc+1, mod 2^32; used as the jal link value.
- epc  out  32  PC captured at the last exception.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=BOOT, if_req=0, fetch_valid=0, fetch_pc=0, epc=0.
- States: BOOT, FETCH, HOLD.
- BOOT:
  - if_req=0.
  - Next edge goes to FETCH unconditionally.
  - exc_req and redirect_valid are ignored in BOOT.
- FETCH:
  - if_req=1; if_addr=pc. if_addr may change while if_req=1 without ack (memory is address-driven).
  - if_ack=1 and no exc/redirect: fetch_valid<=1 and fetch_pc<=pc on the next edge.
  - If additionally stall=0: pc<=pc+1, stay in FETCH.
  - If additionally stall=1: pc holds, go to HOLD.
  - if_ack=0: pc holds, stay in FETCH, fetch_valid<=0.
- HOLD:
  - if_req=0; fetch_valid<=0.
  - stall=0: pc<=pc+1, go to FETCH.
  - stall=1: remain in HOLD.
- Redirect (FETCH or HOLD, no exc_req): pc<=redirect_pc, go to FETCH, regardless of stall.
  - An if_ack in the same cycle is squashed: fetch_valid<=0.
- Exception (FETCH or HOLD): epc<=pc, pc<=EXC_VECTOR, go to FETCH, fetch_valid<=0.
  - Exception overrides a simultaneous redirect_valid, stall and if_ack.
- fetch_valid is 1 for exactly one cycle per accepted, non-squashed fetch. Back-to-back acks give consecutive pulses.
- Arithmetic: 32-bit unsigned; pc=32'hFFFF_FFFF increments to 32'h0000_0000 with no flag.
- Latency:
  - Ack at edge N gives the fetch_valid pulse in cycle N+1.
  - Redirect/exc at edge N gives if_addr=target in cycle N+1.
- rst_n assertion mid-fetch: immediate return to reset values; the outstanding request is abandoned and the ack that follows reset release is ignored until FETCH.

Test Plan:
- Reset release, if_ack tied 1, stall=0 -> BOOT for 1 cycle; then if_addr 0,1,2,3 on consecutive cycles; fetch_valid pulses with fetch_pc 0,1,2 lagging by 1 cycle.
- Steady fetch at pc=5, assert stall for 3 cycles during ack -> fetch_pc=5 valid once; if_req=0 for 3 cycles; then if_addr=6; no duplicate valid for 5.
- redirect_valid with redirect_pc=0x100 in the same cycle as if_ack at pc=9 -> no fetch_valid for 9; next if_addr=0x100; pc_plus1=0x101.
- exc_req together with redirect_valid (0x200) at pc=0x40 -> epc=0x40; next if_addr=0x20; redirect is ignored.
- Start at pc=32'hFFFF_FFFF via redirect, then ack -> pc_plus1=0; next if_addr=0.
- rst_n pulled low mid-FETCH at pc=0x33 -> outputs go to reset values immediately (if_req=0, epc=0); after release, the BOOT→FETCH sequence restarts from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_if
// Instruction-memory fetch handshake between the PC sequencer and memory.
//
// Signals:
//   if_req   sequencer -> memory   fetch request
//   if_addr  sequencer -> memory   fetch word address (always the current PC)
//   if_ack   memory -> sequencer   request accepted, instruction returned
//
// Modports:
//   master   the PC sequencer side
//   slave    the instruction-memory side
// ---------------------------------------------------------------------------
interface pc_fetch_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;

    modport master (
        output if_req,
        output if_addr,
        input  if_ack
    );

    modport slave (
        input  if_req,
        input  if_addr,
        output if_ack
    );
endinterface : pc_fetch_sequencer_if

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Owns the MIPS front-end program counter (word addressed), drives the
// instruction-memory fetch handshake and hands fetched-instruction valid
// pulses to decode. Next-PC priority: exception > redirect > stall > PC+1.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem            if   fetch handshake (master: if_req/if_addr out, if_ack in)
//   stall           in   hazard-unit stall, blocks PC advance
//   redirect_valid  in   taken branch/jump this cycle
//   redirect_pc     in   redirect target word address
//   exc_req         in   single-cycle exception request
//   fetch_valid     out  one-cycle pulse: instruction at fetch_pc is valid
//   fetch_pc        out  PC of the instruction qualified by fetch_valid
//   pc_plus1        out  pc + 1 (mod 2^32), jal link value
//   epc             out  PC captured at the last exception
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pc_fetch_sequencer_if.master        imem,
    input  logic                        stall,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        exc_req,
    output logic                        fetch_valid,
    output logic [31:0]                 fetch_pc,
    output logic [31:0]                 pc_plus1,
    output logic [31:0]                 epc
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] epc_q,         epc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] pc_inc_s;

    // Sequential successor of a word address; wraps silently at 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc_in);
        return pc_in + 32'd1;
    endfunction

    // Incrementer feeding both the sequential next PC and the link value.
    assign pc_inc_s = pc_incr(pc_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            epc_q         <= 32'h0000_0000;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    // Next-state and next-PC selection with exception > redirect > stall > increment.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;

        case (state_q)
            ST_BOOT: begin
                // Redirects, exceptions and stray acks are ignored until fetching starts.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    // An ack arriving with the redirect belongs to the wrong path.
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (imem.if_ack) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    if (stall) begin
                        // Instruction is delivered once; PC parks until the stall clears.
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = pc_inc_s;
                        state_d = ST_FETCH;
                    end
                end else begin
                    // Memory has not answered: keep requesting the same address.
                    state_d = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_d    = pc_inc_s;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                // Unreachable encoding: restart the fetch sequence cleanly.
                state_d = ST_BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Fetch request is a pure decode of the state register, so it never glitches on inputs.
    always_comb begin
        imem.if_req = 1'b0;
        case (state_q)
            ST_FETCH: imem.if_req = 1'b1;
            ST_BOOT:  imem.if_req = 1'b0;
            ST_HOLD:  imem.if_req = 1'b0;
            default:  imem.if_req = 1'b0;
        endcase
    end

    assign imem.if_addr = pc_q;
    assign fetch_valid  = fetch_valid_q;
    assign fetch_pc     = fetch_pc_q;
    assign epc          = epc_q;
    assign pc_plus1     = pc_inc_s;

endmodule : pc_fetch_sequencer

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Scoreboard bench for pc_fetch_sequencer. A driver applies directed and
// random stimulus once per cycle and advances a behavioural model; every
// accepted fetch pushes its PC into a queue that a separate monitor drains
// against the fetch_valid/fetch_pc pulses.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        exc_req = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus1;
    logic [31:0] epc;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pc_plus1       (pc_plus1),
        .epc            (epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: where the PC is, whether the front end is still
    // booting or parked by a stall, and the last exception PC.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_boot;
    bit          m_parked;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_epc    = 32'h0000_0000;
        m_boot   = 1'b1;
        m_parked = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_if_req"},      {31'd0, bus.if_req},  32'd0);
        chk({tag, "_if_addr"},     bus.if_addr,          RESET_PC);
        chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_fetch_pc"},    fetch_pc,             32'd0);
        chk({tag, "_epc"},         epc,                  32'd0);
    endtask

    // One cycle: check the present outputs against the model, drive inputs,
    // then advance the model by the fetch rules.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc,
                        input logic e, input logic a);
        @(negedge clk);
        chk("if_req",   {31'd0, bus.if_req}, {31'd0, ~(m_boot | m_parked)});
        chk("if_addr",  bus.if_addr, m_pc);
        chk("pc_plus1", pc_plus1,    m_pc + 32'd1);
        chk("epc",      epc,         m_epc);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        exc_req        = e;
        bus.if_ack     = a;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (e) begin
            m_epc    = m_pc;
            m_pc     = EXC_VECTOR;
            m_parked = 1'b0;
        end else if (rv) begin
            m_pc     = rpc;
            m_parked = 1'b0;
        end else if (m_parked) begin
            if (!s) begin
                m_pc     = m_pc + 32'd1;
                m_parked = 1'b0;
            end
        end else if (a) begin
            exp_q.push_back(m_pc);
            if (s) m_parked = 1'b1;
            else   m_pc     = m_pc + 32'd1;
        end
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values(tag);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge, a pulse must appear exactly when the model
    // queued an accepted fetch, carrying that fetch's PC.
    initial begin
        logic        exp_v;
        logic [31:0] exp_pc;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                exp_v = (exp_q.size() != 0);
                chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    exp_pc = exp_q.pop_front();
                    if (fetch_valid) chk("fetch_pc", fetch_pc, exp_pc);
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        bus.if_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        #1;
        rst_n = 1'b1;

        // Boot then straight-line fetch with ack tied high.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Stall for three cycles while fetching pc=5.
        step(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("stall_resume_addr", bus.if_addr, 32'd6);

        // Redirect squashes a simultaneous ack at pc=9.
        step(1'b0, 1'b1, 32'd9, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("redir_addr",  bus.if_addr, 32'h100);
        chk("redir_link",  pc_plus1,    32'h101);

        // Exception beats a simultaneous redirect at pc=0x40.
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("exc_epc",  epc,         32'h40);
        chk("exc_addr", bus.if_addr, EXC_VECTOR);

        // Wrap from the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("wrap_addr", bus.if_addr, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Randomised traffic, including top-of-space targets.
        for (int i = 0; i < 2000; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2)))
                                              : $urandom;
            step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0), rpc,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
        end

        // Reset pulled mid-fetch at pc=0x33, with an exception first so epc is non-zero.
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset_mid_cycle("mid");

        // Restart from RESET_PC with ack held high through boot.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_fetch_sequencer
